serial_add_ctrl: RTL and testbench

- Bit-serial WIDTH-bit adder controller that time-shares one full-adder slice across all bit positions.
- The slice is two existing half_adder instances plus an OR for carry-out.
- Sequences operands LSB-first through the slice with a carry register and assembles sum/Cout.
- Start/done handshake toward the requesting logic; used where area matters more than latency.

---
 rtl/serial_add_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half adders + OR) is reused
// for every bit position, LSB first, with a start/done handshake.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Cout
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             s1, c1, slice_bit, c2, slice_carry;
    logic [WIDTH-1:0] res_shift;

    half_adder u_ha_stage1 (
        .a (op_a_q[0]),
        .b (op_b_q[0]),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha_stage2 (
        .a (s1),
        .b (carry_q),
        .s (slice_bit),
        .c (c2)
    );

    assign slice_carry = c1 | c2;

    // New result bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_single_bit
            assign res_shift = slice_bit;
        end else begin : g_multi_bit
            assign res_shift = {slice_bit, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d  = inA;
                    op_b_d  = inB;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_shift;
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                carry_d = slice_carry;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_BIT) begin
                    sum_d   = res_shift;
                    cout_d  = slice_carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit instance for the main scenarios
// and a 1-bit instance for the degenerate width, both checked against plain a+b.

module tb_serial_add_ctrl;
    localparam int W      = 8;
    localparam int PERIOD = 10;

    logic clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    logic         rst_n, start, busy, done, cout;
    logic [W-1:0] in_a, in_b, sum;

    logic rst1_n, start1, a1, b1, busy1, done1, sum1, cout1;

    int checks   = 0;
    int failures = 0;

    // Last completed result as the spec defines it: held until the next add finishes or reset.
    logic [W:0] model_result;

    typedef struct {
        int         busy_cycles;
        int         done_k;
        logic [W:0] result_before;
        logic [W:0] result_at_done;
        logic [W:0] result_after;
        time        done_time;
    } obs_t;

    serial_add_ctrl #(.WIDTH(W)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .inA   (in_a),
        .inB   (in_b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .Cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .start (start1),
        .inA   (a1),
        .inB   (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .Cout  (cout1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Launches one add and records what the DUT shows after each edge (k=0 is the accepting edge).
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit hold_start, input bit scramble,
                                 input logic [W-1:0] new_a, input logic [W-1:0] new_b,
                                 output obs_t o);
        int done_count;
        done_count       = 0;
        o.busy_cycles    = 0;
        o.done_k         = -1;
        o.result_before  = '0;
        o.result_at_done = '0;
        o.result_after   = '0;
        o.done_time      = 0;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        step();
        if (busy) o.busy_cycles++;
        if (done) done_count++;
        if (!hold_start) start = 1'b0;
        if (scramble) begin
            in_a = new_a;
            in_b = new_b;
        end
        for (int k = 1; k <= W + 1; k++) begin
            step();
            if (busy) o.busy_cycles++;
            if (done) begin
                done_count++;
                o.done_k         = k;
                o.result_at_done = {cout, sum};
                o.done_time      = $time;
            end
            if (k == W - 1) o.result_before = {cout, sum};
            if (k == W + 1) o.result_after = {cout, sum};
        end
        if (done_count != 1) o.done_k = -1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        start  = 1'b1;
        in_a   = 8'h12;
        in_b   = 8'h34;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_done got %b want 0", done);
        end
        checks++;
        if ({cout, sum} !== 9'h000) begin
            failures++;
            $display("[TB] FAIL reset_result got %h want 000", {cout, sum});
        end
        model_result = '0;
        rst_n  = 1'b1;
        rst1_n = 1'b1;
    endtask

    task automatic test_accept_after_reset();
        obs_t o;
        logic [W:0] exp;
        exp = ref_add(8'h12, 8'h34);
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, '0, '0, o);
        checks++;
        if (o.done_k !== W) begin
            failures++;
            $display("[TB] FAIL accept_done_cycle got %0d want %0d", o.done_k, W);
        end
        checks++;
        if (o.result_at_done !== exp) begin
            failures++;
            $display("[TB] FAIL accept_result got %h want %h", o.result_at_done, exp);
        end
        model_result = exp;
    endtask

    task automatic test_carry_out();
        obs_t o;
        logic [W:0] prev;
        prev = model_result;
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, '0, '0, o);
        checks++;
        if (o.busy_cycles !== W + 1) begin
            failures++;
            $display("[TB] FAIL carry_busy_cycles got %0d want %0d", o.busy_cycles, W + 1);
        end
        checks++;
        if (o.done_k !== W) begin
            failures++;
            $display("[TB] FAIL carry_done_cycle got %0d want %0d", o.done_k, W);
        end
        checks++;
        if (o.result_before !== prev) begin
            failures++;
            $display("[TB] FAIL carry_result_held got %h want %h", o.result_before, prev);
        end
        checks++;
        if (o.result_at_done !== 9'h100) begin
            failures++;
            $display("[TB] FAIL carry_result got %h want 100", o.result_at_done);
        end
        checks++;
        if (o.result_after !== 9'h100) begin
            failures++;
            $display("[TB] FAIL carry_result_after got %h want 100", o.result_after);
        end
        model_result = 9'h100;
    endtask

    task automatic test_operand_hold();
        obs_t o;
        applyStimulus(8'hA5, 8'h5A, 1'b0, 1'b1, 8'h00, 8'h00, o);
        checks++;
        if (o.result_at_done !== 9'h0FF) begin
            failures++;
            $display("[TB] FAIL hold_result got %h want 0ff", o.result_at_done);
        end
        model_result = 9'h0FF;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        applyStimulus(8'h3C, 8'h0F, 1'b1, 1'b0, '0, '0, o1);
        applyStimulus(8'h80, 8'h80, 1'b1, 1'b0, '0, '0, o2);
        start = 1'b0;
        checks++;
        if (o1.result_at_done !== 9'h04B) begin
            failures++;
            $display("[TB] FAIL b2b_first got %h want 04b", o1.result_at_done);
        end
        checks++;
        if (o2.result_before !== 9'h04B) begin
            failures++;
            $display("[TB] FAIL b2b_held got %h want 04b", o2.result_before);
        end
        checks++;
        if (o2.result_at_done !== 9'h100) begin
            failures++;
            $display("[TB] FAIL b2b_second got %h want 100", o2.result_at_done);
        end
        checks++;
        if (o2.done_time - o1.done_time !== time'((W + 2) * PERIOD)) begin
            failures++;
            $display("[TB] FAIL b2b_spacing got %0t want %0d", o2.done_time - o1.done_time,
                     (W + 2) * PERIOD);
        end
        model_result = 9'h100;
    endtask

    task automatic test_reset_mid_run();
        obs_t o;
        int late_done;
        in_a  = 8'hFF;
        in_b  = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL midreset_busy_done got %b want 00", {busy, done});
        end
        checks++;
        if ({cout, sum} !== 9'h000) begin
            failures++;
            $display("[TB] FAIL midreset_result got %h want 000", {cout, sum});
        end
        late_done = 0;
        for (int k = 0; k < W + 4; k++) begin
            step();
            if (done || busy) late_done++;
        end
        checks++;
        if (late_done !== 0) begin
            failures++;
            $display("[TB] FAIL midreset_aborted got %0d active cycles want 0", late_done);
        end
        model_result = '0;
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, '0, '0, o);
        checks++;
        if (o.result_at_done !== 9'h003) begin
            failures++;
            $display("[TB] FAIL midreset_next got %h want 003", o.result_at_done);
        end
        model_result = 9'h003;
    endtask

    task automatic test_random();
        obs_t o;
        logic [W-1:0] a, b;
        logic [W:0] exp, prev;
        bit hold, scr;
        for (int n = 0; n < 24; n++) begin
            a    = W'($urandom);
            b    = W'($urandom);
            hold = 1'($urandom_range(0, 1));
            scr  = 1'($urandom_range(0, 1));
            exp  = ref_add(a, b);
            prev = model_result;
            applyStimulus(a, b, hold, scr, W'($urandom), W'($urandom), o);
            checks++;
            if (o.done_k !== W || o.busy_cycles !== W + 1) begin
                failures++;
                $display("[TB] FAIL rand_timing n=%0d got done_k=%0d busy=%0d want %0d/%0d",
                         n, o.done_k, o.busy_cycles, W, W + 1);
            end
            checks++;
            if (o.result_before !== prev) begin
                failures++;
                $display("[TB] FAIL rand_held n=%0d got %h want %h", n, o.result_before, prev);
            end
            checks++;
            if (o.result_at_done !== exp) begin
                failures++;
                $display("[TB] FAIL rand_result n=%0d a=%h b=%h got %h want %h",
                         n, a, b, o.result_at_done, exp);
            end
            model_result = exp;
        end
        start = 1'b0;
        step();
    endtask

    task automatic test_width1();
        logic [1:0] exp;
        for (int n = 0; n < 4; n++) begin
            exp    = 2'(n[1]) + 2'(n[0]);
            a1     = n[1];
            b1     = n[0];
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            a1     = ~a1;
            b1     = ~b1;
            checks++;
            if ({busy1, done1} !== 2'b10) begin
                failures++;
                $display("[TB] FAIL w1_run n=%0d got %b want 10", n, {busy1, done1});
            end
            step();
            checks++;
            if ({busy1, done1} !== 2'b11) begin
                failures++;
                $display("[TB] FAIL w1_done n=%0d got %b want 11", n, {busy1, done1});
            end
            checks++;
            if ({cout1, sum1} !== exp) begin
                failures++;
                $display("[TB] FAIL w1_result n=%0d got %b want %b", n, {cout1, sum1}, exp);
            end
            step();
            checks++;
            if ({busy1, done1, cout1, sum1} !== {2'b00, exp}) begin
                failures++;
                $display("[TB] FAIL w1_idle n=%0d got %b want %b", n,
                         {busy1, done1, cout1, sum1}, {2'b00, exp});
            end
        end
    endtask

    initial begin
        #(PERIOD * 20000);
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        in_a   = '0;
        in_b   = '0;
        a1     = 1'b0;
        b1     = 1'b0;
        model_result = '0;
        test_reset();
        test_accept_after_reset();
        test_carry_out();
        test_operand_hold();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
